// File: rtl/irq_controller_pkg.sv
// Shared types and register decode for the interrupt controller.
// Register offsets are expressed as bus_address[4:3] values.
package irq_controller_pkg;

  typedef enum logic [1:0] {
    IRQ_IDLE    = 2'd0,
    IRQ_ASSERT  = 2'd1,
    IRQ_ACK_LOW = 2'd2,
    IRQ_SERVICE = 2'd3
  } irq_state_e;

  localparam logic [1:0] IRQ_PENDING  = 2'd0;  // byte offset 0x00
  localparam logic [1:0] IRQ_ENABLE   = 2'd1;  // byte offset 0x08
  localparam logic [1:0] IRQ_CLAIM    = 2'd2;  // byte offset 0x10
  localparam logic [1:0] IRQ_COMPLETE = 2'd3;  // byte offset 0x18

  localparam logic [63:0] IRQ_BASE_DEFAULT = 64'h0000_3000;

endpackage

// File: rtl/irq_controller_if.sv
// CPU memory-mapped bus as seen by one slave; read data is zero unless selected.
interface irq_controller_if;
  logic [63:0] bus_address;
  logic [63:0] bus_write_data;
  logic        bus_write_enable;
  logic        bus_read_enable;
  logic [63:0] bus_read_data;
  logic        irq_selected;

  modport master (
    output bus_address, bus_write_data, bus_write_enable, bus_read_enable,
    input  bus_read_data, irq_selected
  );

  modport slave (
    input  bus_address, bus_write_data, bus_write_enable, bus_read_enable,
    output bus_read_data, irq_selected
  );
endinterface

// File: rtl/irq_priority_encoder.sv
// Fixed-priority encoder: lowest set request bit wins.
module irq_priority_encoder #(
  parameter int NSRC = 4
) (
  input  logic [NSRC-1:0] req,
  output logic            valid,
  output logic [3:0]      idx
);
  always_comb begin
    valid = |req;
    idx   = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req[i]) idx = 4'(i);
    end
  end
endmodule

// File: rtl/irq_controller.sv
// Edge-capturing interrupt controller: one vector in flight, claim/complete
// handshake over the bus, fixed priority with lowest source index highest.
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter int          NSRC = 4,
  parameter logic [63:0] BASE = IRQ_BASE_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] irq_src,
  irq_controller_if.slave bus,
  output logic [3:0]      interrupt_vector,
  input  logic            interrupt_ack
);

  logic [NSRC-1:0] pending_q, pending_d, enable_q, enable_d, src_dly_q;
  logic [NSRC-1:0] rise, clr, req, cur_mask;
  logic [3:0]      in_service_q, in_service_d, cur_id_q, cur_id_d;
  logic [3:0]      vector_q, vector_d, win_idx;
  logic [63:0]     rdata_q, rdata_d;
  irq_state_e      state_q, state_d;
  logic            sel, wr_en, win_vld;
  logic [1:0]      reg_sel;
  logic            unused_bits;

  assign sel         = (bus.bus_address[63:5] == BASE[63:5]);
  assign reg_sel     = bus.bus_address[4:3];
  assign wr_en       = bus.bus_write_enable && sel;
  assign rise        = irq_src & ~src_dly_q;
  assign req         = pending_q & enable_q;
  assign unused_bits = ^{bus.bus_address[2:0], bus.bus_write_data};

  assign bus.irq_selected  = sel;
  assign bus.bus_read_data = rdata_q;
  assign interrupt_vector  = vector_q;

  irq_priority_encoder #(.NSRC(NSRC)) u_prio (
    .req   (req),
    .valid (win_vld),
    .idx   (win_idx)
  );

  // One-hot of the source currently offered, avoids a variable bit-select
  always_comb begin
    cur_mask = '0;
    for (int k = 0; k < NSRC; k++) cur_mask[k] = (cur_id_q == 4'(k + 1));
  end

  always_comb begin
    state_d      = state_q;
    cur_id_d     = cur_id_q;
    vector_d     = vector_q;
    in_service_d = in_service_q;
    clr          = '0;
    enable_d     = enable_q;
    if (wr_en && reg_sel == IRQ_ENABLE) enable_d = bus.bus_write_data[NSRC-1:0];
    case (state_q)
      IRQ_IDLE: if (win_vld) begin
        cur_id_d = win_idx + 4'd1;
        vector_d = win_idx + 4'd1;
        state_d  = IRQ_ASSERT;
      end
      IRQ_ASSERT: if (interrupt_ack) begin
        clr          = cur_mask;
        in_service_d = cur_id_q;
        vector_d     = '0;
        state_d      = IRQ_ACK_LOW;
      end else if ((enable_q & cur_mask) == '0) begin
        vector_d = '0;
        state_d  = IRQ_IDLE;
      end
      IRQ_ACK_LOW: if (!interrupt_ack) state_d = IRQ_SERVICE;
      default: if (wr_en && reg_sel == IRQ_COMPLETE &&
                   bus.bus_write_data[3:0] == in_service_q) begin
        in_service_d = '0;
        state_d      = IRQ_IDLE;
      end
    endcase
    // A new edge on the ack cycle must not be lost, so set wins over clear
    pending_d = (pending_q & ~clr) | rise;
  end

  // Zero when not addressed so the top-level read mux can simply OR slaves
  always_comb begin
    rdata_d = '0;
    if (bus.bus_read_enable && sel) begin
      case (reg_sel)
        IRQ_PENDING: rdata_d[NSRC-1:0] = pending_q;
        IRQ_ENABLE:  rdata_d[NSRC-1:0] = enable_q;
        IRQ_CLAIM:   rdata_d[3:0]      = in_service_q;
        default:     rdata_d           = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pending_q    <= '0;
      enable_q     <= '0;
      src_dly_q    <= '0;
      in_service_q <= '0;
      cur_id_q     <= '0;
      vector_q     <= '0;
      rdata_q      <= '0;
      state_q      <= IRQ_IDLE;
    end else begin
      pending_q    <= pending_d;
      enable_q     <= enable_d;
      src_dly_q    <= irq_src;
      in_service_q <= in_service_d;
      cur_id_q     <= cur_id_d;
      vector_q     <= vector_d;
      rdata_q      <= rdata_d;
      state_q      <= state_d;
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Directed plus randomized bench for irq_controller against a rule-level model.
module tb_irq_controller;
  localparam int          NSRC = 4;
  localparam logic [63:0] BASE = 64'h0000_3000;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [NSRC-1:0] irq_src = '0;
  logic            ack = 1'b0;
  logic [3:0]      vec;

  irq_controller_if bus_if ();

  irq_controller #(.NSRC(NSRC), .BASE(BASE)) dut (
    .clk              (clk),
    .reset            (reset),
    .irq_src          (irq_src),
    .bus              (bus_if),
    .interrupt_vector (vec),
    .interrupt_ack    (ack)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: phase 0 idle, 1 offering a vector, 2 waiting for ack
  // to drop, 3 being serviced.
  bit [3:0]    m_pend, m_en, m_dly, m_vec;
  int          m_claim, m_cur, m_phase;
  logic [63:0] m_rd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_win(input logic [63:0] a);
    return (a >= BASE) && (a < BASE + 64'd32);
  endfunction

  task automatic mstep();
    logic [63:0] a, new_rd;
    bit          s;
    int          r, win;
    bit [3:0]    rise, clr, req, new_en;
    a = bus_if.bus_address;
    s = in_win(a);
    r = s ? int'((a - BASE) >> 3) : -1;
    if (!reset) begin
      m_pend = 0; m_en = 0; m_dly = 0; m_vec = 0;
      m_claim = 0; m_cur = 0; m_phase = 0; m_rd = 0;
      return;
    end
    new_rd = 0;
    if (bus_if.bus_read_enable && s) begin
      if (r == 0) new_rd = 64'(m_pend);
      else if (r == 1) new_rd = 64'(m_en);
      else if (r == 2) new_rd = 64'(m_claim);
    end
    new_en = m_en;
    if (bus_if.bus_write_enable && s && r == 1) new_en = bus_if.bus_write_data[3:0];
    rise = irq_src & ~m_dly;
    clr  = 0;
    if (m_phase == 0) begin
      req = m_pend & m_en;
      win = -1;
      for (int k = 0; k < NSRC; k++) if (req[k] && win < 0) win = k;
      if (win >= 0) begin m_cur = win + 1; m_vec = 4'(m_cur); m_phase = 1; end
    end else if (m_phase == 1) begin
      if (ack) begin
        clr[m_cur-1] = 1'b1; m_claim = m_cur; m_vec = 0; m_phase = 2;
      end else if (!m_en[m_cur-1]) begin
        m_vec = 0; m_phase = 0;
      end
    end else if (m_phase == 2) begin
      if (!ack) m_phase = 3;
    end else begin
      if (bus_if.bus_write_enable && s && r == 3 &&
          int'(bus_if.bus_write_data[3:0]) == m_claim) begin
        m_claim = 0; m_phase = 0;
      end
    end
    m_pend = (m_pend & ~clr) | rise;
    m_dly  = irq_src;
    m_en   = new_en;
    m_rd   = new_rd;
  endtask

  task automatic tick();
    @(posedge clk);
    mstep();
    #1;
    chk("vector", 64'(vec), 64'(m_vec));
    chk("read_data", bus_if.bus_read_data, m_rd);
    chk("selected", 64'(bus_if.irq_selected), 64'(in_win(bus_if.bus_address)));
  endtask

  task automatic wr(input int r, input logic [63:0] d);
    bus_if.bus_address      = BASE + 64'(r * 8);
    bus_if.bus_write_data   = d;
    bus_if.bus_write_enable = 1'b1;
    tick();
    bus_if.bus_write_enable = 1'b0;
    bus_if.bus_address      = '0;
  endtask

  task automatic rd(input int r, output logic [63:0] v);
    bus_if.bus_address     = BASE + 64'(r * 8);
    bus_if.bus_read_enable = 1'b1;
    tick();
    v = bus_if.bus_read_data;
    bus_if.bus_read_enable = 1'b0;
    bus_if.bus_address     = '0;
  endtask

  initial begin
    logic [63:0] v;
    bus_if.bus_address = '0; bus_if.bus_write_data = '0;
    bus_if.bus_write_enable = 1'b0; bus_if.bus_read_enable = 1'b0;

    // Reset with sources toggling
    irq_src = 4'hF; tick();
    irq_src = 4'h0; tick();
    chk("reset_vector", 64'(vec), 64'd0);
    reset = 1'b1;
    rd(0, v); chk("reset_pending", v, 64'd0);
    rd(1, v); chk("reset_enable", v, 64'd0);
    rd(2, v); chk("reset_claim", v, 64'd0);

    // Single source
    wr(1, 64'h2);
    irq_src = 4'h2; tick();
    irq_src = 4'h0;
    rd(0, v); chk("single_pending", v, 64'h2);
    chk("single_vector", 64'(vec), 64'd2);
    ack = 1'b1; repeat (5) tick();
    ack = 1'b0; tick();
    rd(0, v); chk("single_pending_clr", v, 64'h0);
    rd(2, v); chk("single_claim", v, 64'd2);
    chk("single_vec_zero", 64'(vec), 64'd0);
    wr(3, 64'd2);
    rd(2, v); chk("single_claim_done", v, 64'd0);

    // Priority
    wr(1, 64'hF);
    irq_src = 4'h9; tick();
    irq_src = 4'h0; tick();
    chk("prio_first", 64'(vec), 64'd1);
    ack = 1'b1; tick(); ack = 1'b0; tick();
    wr(3, 64'd1);
    tick();
    chk("prio_second", 64'(vec), 64'd4);
    rd(0, v); chk("prio_pending", v, 64'h8);
    ack = 1'b1; tick(); ack = 1'b0; tick();
    wr(3, 64'd4);

    // Masking and withdraw
    wr(1, 64'h0);
    irq_src = 4'h4; tick(); irq_src = 4'h0; tick();
    rd(0, v); chk("mask_pending", v, 64'h4);
    chk("mask_vector", 64'(vec), 64'd0);
    wr(1, 64'h4); tick();
    chk("unmask_vector", 64'(vec), 64'd3);
    wr(1, 64'h0); tick();
    chk("withdraw_vector", 64'(vec), 64'd0);
    rd(0, v); chk("withdraw_pending", v, 64'h4);
    wr(1, 64'h4); tick();
    ack = 1'b1; tick(); ack = 1'b0; tick();
    wr(3, 64'd3);

    // Boundary: wrong complete id, edge during service, set/clear collision
    wr(1, 64'hF);
    irq_src = 4'h1; tick(); irq_src = 4'h0; tick();
    ack = 1'b1; tick(); ack = 1'b0; tick();
    wr(3, 64'd3);
    rd(2, v); chk("bad_complete_claim", v, 64'd1);
    irq_src = 4'h1; tick(); irq_src = 4'h0;
    rd(0, v); chk("service_pending", v, 64'h1);
    wr(3, 64'd1); tick();
    chk("reassert_vector", 64'(vec), 64'd1);
    irq_src = 4'h1; ack = 1'b1; tick();
    irq_src = 4'h0; ack = 1'b0; tick();
    rd(0, v); chk("collision_pending", v, 64'h1);
    wr(3, 64'd1); tick();
    chk("collision_reassert", 64'(vec), 64'd1);
    ack = 1'b1; tick(); ack = 1'b0; tick();
    wr(3, 64'd1);

    // Reset in the middle of a handshake
    irq_src = 4'h2; tick(); irq_src = 4'h0; tick();
    chk("pre_reset_vector", 64'(vec), 64'd2);
    reset = 1'b0; tick();
    chk("midreset_vector", 64'(vec), 64'd0);
    reset = 1'b1; tick();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      int op, r;
      irq_src = 4'($urandom);
      if ($urandom_range(0, 3) == 0) ack = ~ack;
      reset = ($urandom_range(0, 79) != 0);
      op = $urandom_range(0, 3);
      r  = $urandom_range(0, 3);
      bus_if.bus_read_enable  = (op == 1);
      bus_if.bus_write_enable = (op >= 2);
      if ($urandom_range(0, 7) == 0)
        bus_if.bus_address = ($urandom_range(0, 1) == 1) ? BASE + 64'd32 + 64'(r * 8) : BASE - 64'd8;
      else
        bus_if.bus_address = BASE + 64'(r * 8);
      if (op == 3) bus_if.bus_address = BASE + 64'd24;
      bus_if.bus_write_data = (op == 3 && $urandom_range(0, 1) == 1) ?
                              64'(m_claim) : {32'($urandom), 32'($urandom)};
      tick();
    end
    bus_if.bus_read_enable = 1'b0; bus_if.bus_write_enable = 1'b0;
    ack = 1'b0; irq_src = '0; reset = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
